fpu_unit: RTL and testbench

//  Registered single-precision FP execution unit for the multi-cycle CPU core.

---
 rtl/fpu_pkg.sv | 97 +++++++++
 rtl/fpu_unit_addsub.sv | 106 ++++++++++
 rtl/fpu_unit.sv | 176 +++++++++++++++++
 tb/tb_fpu_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared encodings, exception masks and helpers for the single-precision FP unit.
//   - COP1 opcode / fmt / funct encodings as decoded from the instruction word
//   - exception bit indices and the masks built from them
//   - fp32_t unpack view, classification helpers and the common round/pack step
package fpu_pkg;

    localparam logic [5:0] OP_COP1    = 6'b010001;

    localparam logic [4:0] FMT_ARITH  = 5'b10000;
    localparam logic [4:0] FMT_MFC1   = 5'b00000;
    localparam logic [4:0] FMT_MTC1   = 5'b00100;

    localparam logic [5:0] FUNCT_ADD  = 6'h00;
    localparam logic [5:0] FUNCT_SUB  = 6'h01;
    localparam logic [5:0] FUNCT_MUL  = 6'h02;
    localparam logic [5:0] FUNCT_ABS  = 6'h05;
    localparam logic [5:0] FUNCT_MOV  = 6'h06;
    localparam logic [5:0] FUNCT_NEG  = 6'h07;

    localparam int EXC_INVALID   = 0;
    localparam int EXC_OVERFLOW  = 1;
    localparam int EXC_UNDERFLOW = 2;
    localparam int EXC_INEXACT   = 3;

    localparam logic [3:0] EXC_NONE        = 4'b0000;
    localparam logic [3:0] EXC_M_INVALID   = 4'(1 << EXC_INVALID);
    localparam logic [3:0] EXC_M_OVERFLOW  = 4'(1 << EXC_OVERFLOW);
    localparam logic [3:0] EXC_M_UNDERFLOW = 4'(1 << EXC_UNDERFLOW);
    localparam logic [3:0] EXC_M_INEXACT   = 4'(1 << EXC_INEXACT);

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Value plus exception flags produced by one arithmetic path.
    typedef struct packed {
        logic [31:0] value;
        logic [3:0]  exc;
    } fp_res_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac != 23'd0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac == 23'd0);
    endfunction

    // Zero after denormal flush: any exponent-0 encoding counts as zero.
    function automatic logic is_ftz_zero(input fp32_t x);
        return x.exp == 8'h00;
    endfunction

    // Leading-zero count of a 27-bit vector; 27 when the vector is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Round-to-nearest-even of a normalized 1.xxx mantissa with guard/round/sticky,
    // then range check. exp_in is the biased exponent before rounding.
    function automatic fp_res_t round_pack(input logic               sign,
                                           input logic signed [9:0]  exp_in,
                                           input logic [23:0]        man,
                                           input logic               g,
                                           input logic               r,
                                           input logic               s);
        fp_res_t           res;
        logic [24:0]       rnd;
        logic signed [9:0] e;
        logic              inexact;
        inexact = g | r | s;
        rnd     = {1'b0, man} + {24'b0, g & (r | s | man[0])};
        // A carry out of the mantissa (1.111..1 + ulp) renormalizes to 1.000 with exp+1.
        e       = exp_in + (rnd[24] ? 10'sd1 : 10'sd0);
        if (e >= 10'sd255) begin
            res.value = {sign, 8'hFF, 23'd0};
            res.exc   = EXC_M_OVERFLOW | EXC_M_INEXACT;
        end else if (e <= 10'sd0) begin
            res.value = {sign, 31'd0};
            res.exc   = EXC_M_UNDERFLOW | EXC_M_INEXACT;
        end else begin
            res.value = {sign, e[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
            res.exc   = inexact ? EXC_M_INEXACT : EXC_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/fpu_unit_addsub.sv
// fp_addsub: combinational single-precision add/subtract.
//   a, b       in  32  operands (denormals flushed to signed zero)
//   sub        in  1   1 = a - b (implemented as a + (-b))
//   result     out 32  rounded IEEE-754 single result
//   exception  out 4   [0] invalid, [1] overflow, [2] underflow, [3] inexact
module fp_addsub
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result,
    output logic [3:0]  exception
);

    fp32_t             ua, ub;
    logic              sb_eff;
    logic              a_zero, b_zero;
    logic [23:0]       man_a, man_b;
    logic              swap;
    logic              sign_big;
    logic              eff_sub;
    logic [7:0]        exp_big, exp_small;
    logic [23:0]       man_big, man_small;
    logic [7:0]        shamt;
    logic [26:0]       ext_small;
    logic [26:0]       aligned;
    logic [27:0]       sum;
    logic [26:0]       norm;
    logic signed [9:0] exp_norm;
    logic [4:0]        lz;
    fp_res_t           rounded;

    assign ua     = a;
    assign ub     = b;
    assign sb_eff = ub.sign ^ sub;
    assign a_zero = is_ftz_zero(ua);
    assign b_zero = is_ftz_zero(ub);
    assign man_a  = a_zero ? 24'd0 : {1'b1, ua.frac};
    assign man_b  = b_zero ? 24'd0 : {1'b1, ub.frac};

    // Order operands by magnitude so the subtraction below never goes negative.
    assign swap      = {ub.exp, man_b} > {ua.exp, man_a};
    assign exp_big   = swap ? ub.exp : ua.exp;
    assign exp_small = swap ? ua.exp : ub.exp;
    assign man_big   = swap ? man_b  : man_a;
    assign man_small = swap ? man_a  : man_b;
    assign sign_big  = swap ? sb_eff : ua.sign;
    assign eff_sub   = ua.sign ^ sb_eff;
    assign shamt     = exp_big - exp_small;
    assign ext_small = {man_small, 3'b000};

    // Align: bits shifted past the round position collapse into the sticky bit (bit 0).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        aligned = '0;
        if (shamt >= 8'd27) begin
            aligned = {26'd0, |ext_small};
        end else begin
            aligned = (ext_small >> shamt)
                    | {26'd0, |(ext_small & ~({27{1'b1}} << shamt))};
        end
    end

    assign sum = eff_sub ? ({1'b0, man_big, 3'b000} - {1'b0, aligned})
                         : ({1'b0, man_big, 3'b000} + {1'b0, aligned});

    always_comb begin
        lz       = lzc27(sum[26:0]);
        norm     = sum[26:0] << lz;
        exp_norm = signed'({2'b00, exp_big}) - signed'({5'd0, lz});
        if (sum[27]) begin
            lz       = 5'd0;
            norm     = {sum[27:2], sum[1] | sum[0]};
            exp_norm = signed'({2'b00, exp_big}) + 10'sd1;
        end
    end

    assign rounded = round_pack(sign_big, exp_norm, norm[26:3], norm[2], norm[1], norm[0]);

    always_comb begin
        result    = rounded.value;
        exception = rounded.exc;
        if (is_nan(ua) || is_nan(ub)) begin
            result    = CANON_NAN;
            exception = EXC_M_INVALID;
        end else if (is_inf(ua) && is_inf(ub) && (ua.sign != sb_eff)) begin
            result    = CANON_NAN;
            exception = EXC_M_INVALID;
        end else if (is_inf(ua)) begin
            result    = {ua.sign, 8'hFF, 23'd0};
            exception = EXC_NONE;
        end else if (is_inf(ub)) begin
            result    = {sb_eff, 8'hFF, 23'd0};
            exception = EXC_NONE;
        end else if (a_zero && b_zero) begin
            // Only (-0) + (-0) keeps the negative sign.
            result    = {ua.sign & sb_eff, 31'd0};
            exception = EXC_NONE;
        end else if (sum == 28'd0) begin
            result    = 32'd0;
            exception = EXC_NONE;
        end
    end

endmodule

// File: rtl/fpu_unit.sv
// fpu_unit: registered single-precision FP execution unit, one-cycle latency.
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   in_valid           capture operands/op on this edge
//   opcode, fmt, funct instruction fields selecting mtc1/mfc1/arith op
//   a, b               fs / ft operands (b carries the integer register for mtc1)
//   cmp_a, cmp_b       compare operands for eq / lt
//   out_valid          result/flags valid (one cycle after in_valid)
//   result, exception  IEEE-754 result and {inexact, underflow, overflow, invalid}
//   eq, lt             cmp_a == cmp_b, cmp_a < cmp_b (registered for every op)
module fpu_unit
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [5:0]  opcode,
    input  logic [4:0]  fmt,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [3:0]  exception,
    output logic        eq,
    output logic        lt
);

    // ---------------- add / sub ----------------
    logic [31:0] addsub_result;
    logic [3:0]  addsub_exc;

    fp_addsub u_addsub (
        .a         (a),
        .b         (b),
        .sub       (funct == FUNCT_SUB),
        .result    (addsub_result),
        .exception (addsub_exc)
    );

    // ---------------- multiply ----------------
    fp32_t             ua, ub;
    logic              mul_sign;
    logic              a_zero, b_zero;
    logic [47:0]       prod;
    logic signed [9:0] mul_exp;
    fp_res_t           mul_rounded;
    logic [31:0]       mul_result;
    logic [3:0]        mul_exc;

    assign ua       = a;
    assign ub       = b;
    assign mul_sign = ua.sign ^ ub.sign;
    assign a_zero   = is_ftz_zero(ua);
    assign b_zero   = is_ftz_zero(ub);
    assign prod     = {24'd0, 1'b1, ua.frac} * {24'd0, 1'b1, ub.frac};
    assign mul_exp  = signed'({2'b00, ua.exp}) + signed'({2'b00, ub.exp}) - 10'sd127;

    // Product of two 1.xxx mantissas lies in [1,4); bit 47 selects the normalization.
    always_comb begin
        if (prod[47]) begin
            mul_rounded = round_pack(mul_sign, mul_exp + 10'sd1, prod[47:24],
                                     prod[23], prod[22], |prod[21:0]);
        end else begin
            mul_rounded = round_pack(mul_sign, mul_exp, prod[46:23],
                                     prod[22], prod[21], |prod[20:0]);
        end
    end

    always_comb begin
        mul_result = mul_rounded.value;
        mul_exc    = mul_rounded.exc;
        if (is_nan(ua) || is_nan(ub) ||
            (is_inf(ua) && b_zero) || (is_inf(ub) && a_zero)) begin
            mul_result = CANON_NAN;
            mul_exc    = EXC_M_INVALID;
        end else if (is_inf(ua) || is_inf(ub)) begin
            mul_result = {mul_sign, 8'hFF, 23'd0};
            mul_exc    = EXC_NONE;
        end else if (a_zero || b_zero) begin
            mul_result = {mul_sign, 31'd0};
            mul_exc    = EXC_NONE;
        end
    end

    // ---------------- decode / result select ----------------
    logic [31:0] nxt_result;
    logic [3:0]  nxt_exc;

    always_comb begin
        nxt_result = 32'd0;
        nxt_exc    = EXC_M_INVALID;
        if (opcode == OP_COP1) begin
            case (fmt)
                FMT_MTC1: begin
                    nxt_result = b;
                    nxt_exc    = EXC_NONE;
                end
                FMT_MFC1: begin
                    nxt_result = a;
                    nxt_exc    = EXC_NONE;
                end
                FMT_ARITH: begin
                    case (funct)
                        FUNCT_ADD, FUNCT_SUB: begin
                            nxt_result = addsub_result;
                            nxt_exc    = addsub_exc;
                        end
                        FUNCT_MUL: begin
                            nxt_result = mul_result;
                            nxt_exc    = mul_exc;
                        end
                        // Sign-bit moves are pure bit operations, even on NaN.
                        FUNCT_ABS: begin
                            nxt_result = {1'b0, a[30:0]};
                            nxt_exc    = EXC_NONE;
                        end
                        FUNCT_MOV: begin
                            nxt_result = a;
                            nxt_exc    = EXC_NONE;
                        end
                        FUNCT_NEG: begin
                            nxt_result = {~a[31], a[30:0]};
                            nxt_exc    = EXC_NONE;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // ---------------- compare ----------------
    fp32_t cx, cy;
    logic  cmp_nan;
    logic  both_zero;
    logic  nxt_eq, nxt_lt;

    assign cx        = cmp_a;
    assign cy        = cmp_b;
    assign cmp_nan   = is_nan(cx) || is_nan(cy);
    assign both_zero = (cmp_a[30:0] == 31'd0) && (cmp_b[30:0] == 31'd0);
    assign nxt_eq    = !cmp_nan && ((cmp_a == cmp_b) || both_zero);

    always_comb begin
        nxt_lt = 1'b0;
        if (!cmp_nan && !both_zero) begin
            if (cx.sign != cy.sign) nxt_lt = cx.sign;
            else if (!cx.sign)      nxt_lt = cmp_a[30:0] < cmp_b[30:0];
            else                    nxt_lt = cmp_a[30:0] > cmp_b[30:0];
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so all outputs update together.
        if (!rstn) begin
            out_valid <= 1'b0;
            result    <= 32'd0;
            exception <= 4'd0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            result    <= nxt_result;
            exception <= nxt_exc;
            eq        <= nxt_eq;
            lt        <= nxt_lt;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_unit.sv
// tb_fpu_unit: scoreboard bench for fpu_unit. Expected results are queued as each
// op is driven and compared when out_valid returns one cycle later.
module tb_fpu_unit;

    localparam logic [5:0] OP_C1 = 6'b010001;
    localparam logic [4:0] F_AR  = 5'b10000;
    localparam logic [4:0] F_MF  = 5'b00000;
    localparam logic [4:0] F_MT  = 5'b00100;
    localparam logic [5:0] ADD   = 6'h00;
    localparam logic [5:0] SUB   = 6'h01;
    localparam logic [5:0] MUL   = 6'h02;
    localparam logic [5:0] ABS   = 6'h05;
    localparam logic [5:0] MOV   = 6'h06;
    localparam logic [5:0] NEG   = 6'h07;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [5:0]  opcode;
    logic [4:0]  fmt;
    logic [5:0]  funct;
    logic [31:0] a, b, cmp_a, cmp_b;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  exception;
    logic        eq, lt;

    fpu_unit dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .fmt       (fmt),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .out_valid (out_valid),
        .result    (result),
        .exception (exception),
        .eq        (eq),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [3:0]  exc;
        logic        eq;
        logic        lt;
        int          cyc;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;
    logic [31:0] hold_res = 32'd0;
    logic [3:0]  hold_exc = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic issue(input string tag, input logic [5:0] op, input logic [4:0] fm,
                         input logic [5:0] fn, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] ca, input logic [31:0] cb,
                         input logic [31:0] er, input logic [3:0] ee,
                         input logic eeq, input logic elt);
        sb_item_t e;
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = op;
        fmt      = fm;
        funct    = fn;
        a        = xa;
        b        = xb;
        cmp_a    = ca;
        cmp_b    = cb;
        e.tag = tag;
        e.res = er;
        e.exc = ee;
        e.eq  = eeq;
        e.lt  = elt;
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic arith(input string tag, input logic [5:0] fn, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [31:0] er, input logic [3:0] ee,
                         input logic eeq, input logic elt);
        issue(tag, OP_C1, F_AR, fn, xa, xb, xa, xb, er, ee, eeq, elt);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: pops one expectation per out_valid, checks hold behaviour otherwise.
    initial begin : monitor
        sb_item_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rstn) begin
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.tag, "/res"}, result, e.res);
                        check({e.tag, "/exc"}, 32'(exception), 32'(e.exc));
                        check({e.tag, "/eq"},  32'(eq), 32'(e.eq));
                        check({e.tag, "/lt"},  32'(lt), 32'(e.lt));
                        check({e.tag, "/lat"}, cyc, e.cyc + 1);
                        hold_res = e.res;
                        hold_exc = e.exc;
                    end
                end else begin
                    check("hold/res", result, hold_res);
                    check("hold/exc", 32'(exception), 32'(hold_exc));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        in_valid = 1'b0;
        opcode   = '0;
        fmt      = '0;
        funct    = '0;
        a        = '0;
        b        = '0;
        cmp_a    = '0;
        cmp_b    = '0;
        rstn     = 1'b1;
        #1 rstn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/valid", 32'(out_valid), 32'd0);
        check("rst/res",   result, 32'd0);
        check("rst/exc",   32'(exception), 32'd0);
        check("rst/eq",    32'(eq), 32'd0);
        check("rst/lt",    32'(lt), 32'd0);
        @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Back-to-back arithmetic, moves and unsupported ops; compare pair = (a, b).
        arith("add_1_2",     ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'h0, 0, 1);
        arith("mul_1p5_2",   MUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, 0, 1);
        arith("mul_ovf",     MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'hA, 0, 0);
        arith("sub_zero",    SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h0, 1, 0);
        arith("inf_m_inf",   ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h1, 0, 0);
        issue("mtc1", OP_C1, F_MT, 6'h00, 32'h00000000, 32'h12345678,
              32'h00000000, 32'h12345678, 32'h12345678, 4'h0, 0, 1);
        issue("mfc1", OP_C1, F_MF, 6'h00, 32'hBF800000, 32'h00000000,
              32'hBF800000, 32'h00000000, 32'hBF800000, 4'h0, 0, 1);
        arith("neg_1",       NEG, 32'h3F800000, 32'h00000000, 32'hBF800000, 4'h0, 0, 0);
        arith("rne_tie_dn",  ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h8, 0, 0);
        arith("rne_tie_up",  ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'h8, 0, 0);
        arith("sub_3_1",     SUB, 32'h40400000, 32'h3F800000, 32'h40000000, 4'h0, 0, 0);
        arith("sub_norm",    SUB, 32'h3F800001, 32'h3F800000, 32'h34000000, 4'h0, 0, 0);
        arith("sub_neg_b",   SUB, 32'h3F800000, 32'hBF800000, 32'h40000000, 4'h0, 0, 0);
        arith("mul_sign",    MUL, 32'h3F800000, 32'hC0000000, 32'hC0000000, 4'h0, 0, 0);
        arith("mul_tiny",    MUL, 32'h80800000, 32'h3F000000, 32'h80000000, 4'hC, 0, 1);
        arith("denorm_ftz",  ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'h0, 0, 1);
        arith("nan_add",     ADD, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h1, 0, 0);
        arith("zero_x_inf",  MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'h1, 0, 1);
        arith("nz_p_nz",     ADD, 32'h80000000, 32'h80000000, 32'h80000000, 4'h0, 1, 0);
        arith("nz_p_pz",     ADD, 32'h80000000, 32'h00000000, 32'h00000000, 4'h0, 1, 0);
        arith("abs_nan",     ABS, 32'hFF800001, 32'h00000000, 32'h7F800001, 4'h0, 0, 0);
        arith("mov_nan",     MOV, 32'h7FC00001, 32'h00000000, 32'h7FC00001, 4'h0, 0, 0);
        issue("bad_opcode", 6'h00, F_AR, ADD, 32'h3F800000, 32'h3F800000,
              32'h3F800000, 32'h3F800000, 32'h00000000, 4'h1, 1, 0);
        arith("bad_funct",   6'h03, 32'h40000000, 32'h3F800000, 32'h00000000, 4'h1, 0, 0);
        issue("bad_fmt", OP_C1, 5'b10001, ADD, 32'hC0000000, 32'hBF800000,
              32'hC0000000, 32'hBF800000, 32'h00000000, 4'h1, 0, 1);
        idle();
        idle();

        // Compare-focused ops after a gap; result comes from mtc1 of b.
        issue("cmp_pz_nz",  OP_C1, F_MT, 6'h00, 32'h0, 32'h00000011,
              32'h00000000, 32'h80000000, 32'h00000011, 4'h0, 1, 0);
        issue("cmp_m2_1",   OP_C1, F_MT, 6'h00, 32'h0, 32'h00000022,
              32'hC0000000, 32'h3F800000, 32'h00000022, 4'h0, 0, 1);
        issue("cmp_nan",    OP_C1, F_MT, 6'h00, 32'h0, 32'h00000033,
              32'h7FC00000, 32'h3F800000, 32'h00000033, 4'h0, 0, 0);
        issue("cmp_m1_m2",  OP_C1, F_MT, 6'h00, 32'h0, 32'h00000044,
              32'hBF800000, 32'hC0000000, 32'h00000044, 4'h0, 0, 0);
        issue("cmp_nz_pz",  OP_C1, F_MT, 6'h00, 32'h0, 32'h00000055,
              32'h80000000, 32'h00000000, 32'h00000055, 4'h0, 1, 0);
        issue("cmp_eq_1",   OP_C1, F_MT, 6'h00, 32'h0, 32'h00000066,
              32'h3F800000, 32'h3F800000, 32'h00000066, 4'h0, 1, 0);
        idle();
        repeat (4) @(posedge clk);
        #2;
        check("drain", sb_q.size(), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        mon_en   = 1'b0;
        in_valid = 1'b1;
        opcode   = OP_C1;
        fmt      = F_AR;
        funct    = ADD;
        a        = 32'h3F800000;
        b        = 32'h40000000;
        cmp_a    = 32'h3F800000;
        cmp_b    = 32'h3F800000;
        @(posedge clk);
        #2;
        check("pre_rst/valid", 32'(out_valid), 32'd1);
        check("pre_rst/res",   result, 32'h40400000);
        rstn = 1'b0;
        #1;
        check("mid_rst/valid", 32'(out_valid), 32'd0);
        check("mid_rst/res",   result, 32'd0);
        check("mid_rst/exc",   32'(exception), 32'd0);
        check("mid_rst/eq",    32'(eq), 32'd0);
        check("mid_rst/lt",    32'(lt), 32'd0);
        @(posedge clk);
        #1;
        check("rst_held/valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst/valid", 32'(out_valid), 32'd0);
        check("post_rst/res",   result, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst/valid2", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
